// File: rtl/rand_hl_classifier.sv
// Random-bitstring high/low classifier: a Galois LFSR emits one bit per rate tick,
// the bits are packed into WIDTH-bit words, and each word is classified by popcount.
module rand_hl_classifier #(
  parameter int          WIDTH = 8,
  parameter logic [15:0] SEED  = 16'hACE1,
  parameter logic [15:0] TAPS  = 16'hB400,
  parameter int          DIV_W = 4,
  localparam int         CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [DIV_W-1:0] div_sel,
  input  logic [CW-1:0]    thresh,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  output logic             is_high,
  output logic [7:0]       hi_cnt,
  output logic [7:0]       lo_cnt
);

  localparam int          BW        = $clog2(WIDTH);
  localparam logic [15:0] SEED_EFF  = (SEED == 16'h0000) ? 16'h0001 : SEED;
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] FILL     = 2'd1;
  localparam logic [1:0] CLASSIFY = 2'd2;

  logic [1:0]       state;
  logic [15:0]      lfsr;
  logic [WIDTH-1:0] word, hi_reg, lo_reg;
  logic [DIV_W-1:0] div_cnt;
  logic [BW-1:0]    bit_cnt;

  logic             tick;
  logic [15:0]      lfsr_nxt;
  logic [CW-1:0]    pc;
  logic             h;
  logic [WIDTH-1:0] hi_nxt, lo_nxt, sel;

  // >= rather than == so a lowered div_sel cannot strand div_cnt above it
  assign tick     = (div_cnt >= div_sel);
  assign lfsr_nxt = (lfsr >> 1) ^ (lfsr[0] ? TAPS : 16'h0000);

  always_comb begin
    pc = '0;
    for (int i = 0; i < WIDTH; i++) pc = pc + CW'(word[i]);
  end

  assign h      = (pc >= thresh);
  assign hi_nxt = h ? word : hi_reg;
  assign lo_nxt = h ? lo_reg : word;

  // mode selection sees this edge's hi/lo update
  always_comb begin
    case (mode)
      2'd0:    sel = word;
      2'd1:    sel = hi_nxt;
      2'd2:    sel = lo_nxt;
      default: sel = hi_nxt ^ lo_nxt;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      lfsr      <= SEED_EFF;
      word      <= '0;
      hi_reg    <= '0;
      lo_reg    <= '0;
      out       <= '0;
      out_valid <= 1'b0;
      is_high   <= 1'b0;
      hi_cnt    <= '0;
      lo_cnt    <= '0;
      div_cnt   <= '0;
      bit_cnt   <= '0;
    end else begin
      out_valid <= 1'b0;
      if (en) begin
        case (state)
          IDLE: state <= FILL;
          FILL: begin
            if (tick) begin
              div_cnt <= '0;
              lfsr    <= lfsr_nxt;
              word    <= {word[WIDTH-2:0], lfsr[0]};
              if (bit_cnt == LAST_BIT) begin
                bit_cnt <= '0;
                state   <= CLASSIFY;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end else begin
              div_cnt <= div_cnt + 1'b1;
            end
          end
          CLASSIFY: begin
            hi_reg    <= hi_nxt;
            lo_reg    <= lo_nxt;
            if (h && hi_cnt != 8'hFF) hi_cnt <= hi_cnt + 1'b1;
            if (!h && lo_cnt != 8'hFF) lo_cnt <= lo_cnt + 1'b1;
            is_high   <= h;
            out       <= sel;
            out_valid <= 1'b1;
            state     <= FILL;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rand_hl_classifier.sv
// Scoreboard bench: a word-level model pushes expected classifications and the
// en-edge index at which each should appear; a monitor pops on every out_valid.
module tb_rand_hl_classifier;
  localparam int W = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic [3:0] div_sel = '0;
  logic [3:0] thresh = '0;
  logic [1:0] mode = '0;
  logic [W-1:0] out;
  logic       out_valid, is_high;
  logic [7:0] hi_cnt, lo_cnt;

  rand_hl_classifier #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .en(en), .div_sel(div_sel), .thresh(thresh), .mode(mode),
    .out(out), .out_valid(out_valid), .is_high(is_high), .hi_cnt(hi_cnt), .lo_cnt(lo_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] out;
    logic         h;
    int           hc;
    int           lc;
    int           edge_n;
  } exp_t;

  exp_t q[$];
  int n_cmp = 0, n_bad = 0, n_seen = 0, ecount = 0;

  logic [15:0]  m_lfsr;
  logic [W-1:0] m_hi, m_lo;
  int           m_hc, m_lc, m_words;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // One word from the LFSR bit stream, classified by counting ones.
  task automatic model_word(input int d);
    logic [W-1:0] w;
    int pc;
    bit b;
    exp_t e;
    w = '0;
    pc = 0;
    for (int i = 0; i < W; i++) begin
      b = m_lfsr[0];
      m_lfsr = (m_lfsr >> 1) ^ (b ? 16'hB400 : 16'h0000);
      w = {w[W-2:0], b};
      pc += int'(b);
    end
    e.h = (pc >= int'(thresh));
    if (e.h) begin m_hi = w; m_hc = (m_hc < 255) ? m_hc + 1 : 255; end
    else     begin m_lo = w; m_lc = (m_lc < 255) ? m_lc + 1 : 255; end
    case (mode)
      2'd0: e.out = w;
      2'd1: e.out = m_hi;
      2'd2: e.out = m_lo;
      default: e.out = m_hi ^ m_lo;
    endcase
    e.hc = m_hc;
    e.lc = m_lc;
    e.edge_n = W * (d + 1) + 2 + m_words * (W * (d + 1) + 1);
    m_words++;
    q.push_back(e);
  endtask

  // Monitor: counts en=1 edges since reset, checks holds while paused, pops on out_valid.
  always @(posedge clk) begin
    logic en_s;
    logic [W-1:0] p_out;
    logic p_h;
    logic [7:0] p_hc, p_lc;
    exp_t e;
    en_s = en;
    p_out = out; p_h = is_high; p_hc = hi_cnt; p_lc = lo_cnt;
    if (rst) ecount = 0;
    else if (en_s) ecount++;
    #1;
    if (!rst && !en_s) begin
      check("pause_out", {24'd0, out}, {24'd0, p_out});
      check("pause_cnt", {16'd0, hi_cnt, lo_cnt}, {16'd0, p_hc, p_lc});
      check("pause_valid", {31'd0, out_valid | (is_high ^ p_h)}, 32'd0);
    end
    if (!rst && out_valid) begin
      n_seen++;
      if (q.size() == 0) begin
        check("unexpected_valid", 32'd1, 32'd0);
      end else begin
        e = q.pop_front();
        check("out", {24'd0, out}, {24'd0, e.out});
        check("is_high", {31'd0, is_high}, {31'd0, e.h});
        check("hi_cnt", {24'd0, hi_cnt}, e.hc);
        check("lo_cnt", {24'd0, lo_cnt}, e.lc);
        check("timing", ecount, e.edge_n);
      end
    end
  end

  task automatic do_reset(input int d, input int t, input int m);
    @(negedge clk);
    rst = 1'b1;
    en = 1'b0;
    #1;
    check("rst_out", {24'd0, out}, 32'd0);
    check("rst_flags", {30'd0, out_valid, is_high}, 32'd0);
    check("rst_cnt", {16'd0, hi_cnt, lo_cnt}, 32'd0);
    q.delete();
    div_sel = 4'(d);
    thresh = 4'(t);
    mode = 2'(m);
    m_lfsr = 16'hACE1;
    m_hi = '0; m_lo = '0; m_hc = 0; m_lc = 0; m_words = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    n_seen = 0;
  endtask

  task automatic run_phase(input int d, input int t, input int m, input int nw,
                           input int pause_pct, input bit long_pause);
    int budget;
    do_reset(d, t, m);
    for (int k = 0; k < nw; k++) model_word(d);
    budget = 0;
    while (n_seen < nw && budget < 20000) begin
      @(negedge clk);
      if (long_pause && budget == 25) begin
        en = 1'b0;
        repeat (20) @(negedge clk);
      end
      en = ($urandom_range(0, 99) >= pause_pct);
      budget++;
    end
    if (budget >= 20000) check("timeout", 32'd1, 32'd0);
    @(negedge clk);
    en = 1'b0;
    repeat (2) @(negedge clk);
    check("drain", q.size(), 32'd0);
  endtask

  initial begin
    run_phase(0, 4, 0, 6, 0, 1'b0);    // first word 0x87 lands high
    run_phase(0, 5, 1, 3, 0, 1'b0);    // 0x87 goes low; hi_reg still 0
    run_phase(3, 4, 3, 4, 0, 1'b0);    // 33-cycle word period
    run_phase(0, 4, 2, 6, 0, 1'b1);    // 20-cycle pause mid-fill
    run_phase(0, 0, 1, 300, 0, 1'b0);  // hi_cnt saturates
    run_phase(1, 9, 2, 10, 0, 1'b0);   // every word low
    run_phase(2, 15, 3, 5, 10, 1'b0);  // thresh far beyond WIDTH
    for (int r = 0; r < 4; r++)
      run_phase($urandom_range(0, 3), $urandom_range(0, 9), $urandom_range(0, 3),
                $urandom_range(5, 15), 20, 1'b0);
    // reset mid-word after some outputs, then confirm the sequence restarts
    run_phase(0, 4, 0, 3, 0, 1'b0);
    @(negedge clk);
    en = 1'b1;
    repeat (6) @(negedge clk);
    run_phase(0, 4, 0, 2, 0, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
